// File: rtl/dv_axi_ram_initiator_pkg.sv
// Shared definitions for the DV AXI RAM initiator: FSM encodings, AXI constants,
// the seeded data pattern and the 4 KB boundary check.
package dv_axi_init_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CHK  = 3'd1;
  localparam logic [2:0] ST_AW   = 3'd2;
  localparam logic [2:0] ST_W    = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_AR   = 3'd5;
  localparam logic [2:0] ST_R    = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_EXOKAY   = 2'b01;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  // Widest data bus the pattern helper supports; unused upper words stay zero.
  localparam int DATA_W_MAX = 1024;

  // Word k of beat b is seed + b*words + k (mod 2^32).
  function automatic logic [DATA_W_MAX-1:0] pattern_beat(
    input logic [31:0] seed,
    input logic [7:0]  beat,
    input int unsigned words
  );
    logic [DATA_W_MAX-1:0] d;
    logic [31:0]           base;
    d    = '0;
    base = seed + ({24'd0, beat} * words);
    for (int k = 0; k < DATA_W_MAX / 32; k++) begin
      if (k < int'(words)) d[k*32 +: 32] = base + 32'(k);
    end
    return d;
  endfunction

  // True when an aligned burst of len+1 beats of 2^size bytes runs past a 4 KB page.
  function automatic logic crosses_4k(
    input logic [11:0] addr_lo,
    input logic [7:0]  len,
    input logic [2:0]  size
  );
    logic [16:0] bytes;
    logic [16:0] off;
    logic [16:0] span;
    bytes = 17'd1 << size;
    off   = {5'd0, addr_lo} & ~(bytes - 17'd1);
    span  = off + ((17'(len) + 17'd1) * bytes);
    return span > 17'd4096;
  endfunction

endpackage

// File: rtl/dv_axi_ram_initiator_if.sv
// AXI4 manager/subordinate bundle used between the initiator and the RAM under test.
// Handshakes: a beat transfers on a rising edge where valid and ready are both high;
// a source holds valid and its payload stable until that edge, ready may toggle freely.
interface dv_axi_ram_initiator_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/dv_axi_ram_initiator.sv
// Single-burst AXI4 write / read-and-check initiator for exercising a RAM subordinate.
// One command in flight; write data is a seeded pattern that the read path checks against.
module dv_axi_ram_initiator
  import dv_axi_init_pkg::*;
#(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [31:0]           cmd_seed,

  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic                  done_illegal,
  output logic [15:0]           done_mism_cnt,
  output logic                  proto_err,
  output logic [2:0]            dbg_state,

  dv_axi_ram_initiator_if.master m_axi
);

  localparam int         BYTES    = DATA_WIDTH / 8;
  localparam int         SIZE     = $clog2(BYTES);
  localparam logic [2:0] AXI_SIZE = 3'(SIZE);
  localparam int         WORDS    = DATA_WIDTH / 32;

  logic [2:0]            state;
  logic                  out_of_reset;
  logic                  q_write;
  logic [ADDR_WIDTH-1:0] q_addr;
  logic [7:0]            q_len;
  logic [ID_WIDTH-1:0]   q_id;
  logic [31:0]           q_seed;
  logic [7:0]            beat;
  logic                  illegal;
  logic [15:0]           mism_cnt;
  logic [1:0]            resp_max;
  logic                  proto_err_q;

  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic                  last_beat;
  logic [DATA_W_MAX-1:0] pat_full;
  logic [DATA_W_MAX-1:0] rdata_ext;
  logic                  beat_mismatch;

  assign aligned_addr  = q_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign last_beat     = (beat == q_len);
  // Pattern depends only on the latched seed and beat index, never on ready.
  assign pat_full      = pattern_beat(q_seed, beat, 32'(WORDS));
  assign rdata_ext     = DATA_W_MAX'(m_axi.rdata);
  assign beat_mismatch = (rdata_ext != pat_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_of_reset <= 1'b0;
      q_write      <= 1'b0;
      q_addr       <= '0;
      q_len        <= '0;
      q_id         <= '0;
      q_seed       <= '0;
      beat         <= '0;
      illegal      <= 1'b0;
      mism_cnt     <= '0;
      resp_max     <= RESP_OKAY;
      proto_err_q  <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            q_write  <= cmd_write;
            q_addr   <= cmd_addr;
            q_len    <= cmd_len;
            q_id     <= cmd_id;
            q_seed   <= cmd_seed;
            beat     <= '0;
            illegal  <= 1'b0;
            mism_cnt <= '0;
            resp_max <= RESP_OKAY;
            state    <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (crosses_4k(q_addr[11:0], q_len, AXI_SIZE)) begin
            illegal <= 1'b1;
            state   <= ST_DONE;
          end else begin
            state <= q_write ? ST_AW : ST_AR;
          end
        end
        ST_AW: begin
          if (m_axi.awready) begin
            beat  <= '0;
            state <= ST_W;
          end
        end
        ST_W: begin
          if (m_axi.wready) begin
            if (last_beat) state <= ST_B;
            else           beat  <= beat + 8'd1;
          end
        end
        ST_B: begin
          if (m_axi.bvalid) begin
            resp_max <= m_axi.bresp;
            if (m_axi.bid != q_id) proto_err_q <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_AR: begin
          if (m_axi.arready) begin
            beat  <= '0;
            state <= ST_R;
          end
        end
        ST_R: begin
          if (m_axi.rvalid) begin
            if (beat_mismatch && (mism_cnt != 16'hFFFF)) mism_cnt <= mism_cnt + 16'd1;
            if (m_axi.rresp > resp_max) resp_max <= m_axi.rresp;
            if (m_axi.rid != q_id) proto_err_q <= 1'b1;
            if (m_axi.rlast != last_beat) proto_err_q <= 1'b1;
            // A missing rlast still ends the burst at the expected final beat.
            if (m_axi.rlast || last_beat) state <= ST_DONE;
            else                          beat  <= beat + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = out_of_reset && (state == ST_IDLE);
  assign done_valid    = (state == ST_DONE);
  assign done_resp     = resp_max;
  assign done_illegal  = illegal;
  assign done_mism_cnt = mism_cnt;
  assign proto_err     = proto_err_q;
  assign dbg_state     = state;

  assign m_axi.awid    = q_id;
  assign m_axi.awaddr  = aligned_addr;
  assign m_axi.awlen   = q_len;
  assign m_axi.awsize  = AXI_SIZE;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = CACHE_DEFAULT;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (state == ST_AW);

  assign m_axi.wdata   = pat_full[DATA_WIDTH-1:0];
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = last_beat;
  assign m_axi.wvalid  = (state == ST_W);

  assign m_axi.bready  = (state == ST_B);

  assign m_axi.arid    = q_id;
  assign m_axi.araddr  = aligned_addr;
  assign m_axi.arlen   = q_len;
  assign m_axi.arsize  = AXI_SIZE;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = CACHE_DEFAULT;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state == ST_AR);

  assign m_axi.rready  = (state == ST_R);

endmodule

// File: tb/tb_dv_axi_ram_initiator.sv
// Directed bench for dv_axi_ram_initiator with a cycle-based RAM subordinate model.
module tb_dv_axi_ram_initiator;
  import dv_axi_init_pkg::*;

  localparam int AW = 33;
  localparam int DW = 256;
  localparam int IW = 8;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [IW-1:0] cmd_id;
  logic [31:0]   cmd_seed;
  logic          done_valid, done_illegal, proto_err;
  logic [1:0]    done_resp;
  logic [15:0]   done_mism_cnt;
  logic [2:0]    dbg_state;

  dv_axi_ram_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  dv_axi_ram_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_seed(cmd_seed),
    .done_valid(done_valid), .done_resp(done_resp), .done_illegal(done_illegal),
    .done_mism_cnt(done_mism_cnt), .proto_err(proto_err), .dbg_state(dbg_state),
    .m_axi(axi)
  );

  int checks = 0;
  int errors = 0;

  // Subordinate model knobs and monitors
  logic [DW-1:0] mem [int];
  int aw_stall_left = 0, w_stall_left = 0;
  bit w_gaps = 0;
  int rlast_early_beat = -1, rid_override = -1, rresp_err_beat = -1;
  int awvalid_seen = 0, arvalid_seen = 0, w_hs_count = 0, w_unstable = 0, wlast_err = 0, wstrb_bad = 0;
  logic [AW-1:0] last_awaddr;
  logic [12:0]   last_awconst;

  bit            aw_have, b_pending, b_hs, ar_have, r_hs, w_prev_stall, prev_wlast;
  logic [DW-1:0] prev_wdata;
  int            wr_base, wr_len, w_beat, rd_base, rd_len, r_beat;
  logic [IW-1:0] wr_id, rd_id;

  // Decisions are made on the falling edge; a handshake counts at the following rising edge.
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = '0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = 0; axi.rlast = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0;
        axi.rvalid = 0; axi.rlast = 0;
        aw_have = 0; b_pending = 0; b_hs = 0; ar_have = 0; r_hs = 0; w_prev_stall = 0;
        w_beat = 0; r_beat = 0;
      end else begin
        if (axi.awvalid) awvalid_seen++;
        if (axi.arvalid) arvalid_seen++;
        if (b_hs) axi.bvalid = 0;
        if (r_hs) begin
          axi.rvalid = 0;
          if (axi.rlast) ar_have = 0; else r_beat++;
        end
        if (b_pending && !axi.bvalid) begin
          axi.bvalid = 1; axi.bid = wr_id; axi.bresp = RESP_OKAY; b_pending = 0;
        end
        axi.wready = 0;
        if (axi.wvalid && aw_have) begin
          if (w_prev_stall && (axi.wdata !== prev_wdata || axi.wlast !== prev_wlast)) w_unstable++;
          prev_wdata = axi.wdata; prev_wlast = axi.wlast;
          if (w_stall_left > 0) w_stall_left--;
          else if (!(w_gaps && $urandom_range(0, 2) == 0)) begin
            axi.wready = 1;
            mem[wr_base + w_beat] = axi.wdata;
            w_hs_count++;
            if (axi.wstrb !== '1) wstrb_bad++;
            if (axi.wlast !== (w_beat == wr_len)) wlast_err++;
            if (axi.wlast) begin aw_have = 0; b_pending = 1; end
            w_beat++;
          end
          w_prev_stall = !axi.wready;
        end
        axi.awready = 0;
        if (axi.awvalid && !aw_have && !b_pending && !axi.bvalid) begin
          if (aw_stall_left > 0) aw_stall_left--;
          else begin
            axi.awready = 1; aw_have = 1; w_beat = 0; w_prev_stall = 0;
            wr_base = int'(axi.awaddr >> 5); wr_len = int'(axi.awlen); wr_id = axi.awid;
            last_awaddr  = axi.awaddr;
            last_awconst = {axi.awsize, axi.awburst, axi.awcache, axi.awlock, axi.awprot};
          end
        end
        if (ar_have && !axi.rvalid) begin
          axi.rvalid = 1;
          axi.rdata  = mem.exists(rd_base + r_beat) ? mem[rd_base + r_beat] : '0;
          axi.rid    = (rid_override >= 0) ? IW'(rid_override) : rd_id;
          axi.rresp  = (r_beat == rresp_err_beat) ? RESP_SLVERR : RESP_OKAY;
          axi.rlast  = (r_beat == rd_len) || (r_beat == rlast_early_beat);
        end
        axi.arready = 0;
        if (axi.arvalid && !ar_have) begin
          axi.arready = 1; ar_have = 1; r_beat = 0;
          rd_base = int'(axi.araddr >> 5); rd_len = int'(axi.arlen); rd_id = axi.arid;
        end
        b_hs = axi.bvalid && axi.bready;
        r_hs = axi.rvalid && axi.rready;
      end
    end
  end

  // Results of the most recent command
  logic [1:0]  res_resp;
  logic        res_ill, res_again, res_rdy_done, res_rdy_after;
  logic [15:0] res_mism;
  int          res_cyc, res_first;

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [IW-1:0] id, input logic [31:0] seed);
    int n;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id; cmd_seed = seed;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0; res_first = -1;
    while (done_valid !== 1'b1 && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (res_first < 0 && (axi.awvalid === 1'b1 || axi.arvalid === 1'b1)) res_first = cyc;
    end
    res_cyc = cyc;
    checks++;
    if (done_valid !== 1'b1) begin
      errors++; $display("FAIL done_timeout: done_valid=%b after %0d cycles, expected 1", done_valid, cyc);
    end
    res_resp = done_resp; res_ill = done_illegal; res_mism = done_mism_cnt; res_rdy_done = cmd_ready;
    @(negedge clk);
    res_again = done_valid; res_rdy_after = cmd_ready;
  endtask

  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [IW-1:0] id, input logic [31:0] seed);
    send_cmd(wr, addr, len, id, seed);
    wait_done();
  endtask

  task automatic test_reset();
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0; cmd_seed = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, done_valid, done_illegal, proto_err, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 9'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000000000",
        {cmd_ready, done_valid, done_illegal, proto_err, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
    end
    checks++;
    if ({done_resp, done_mism_cnt, dbg_state} !== 21'd0) begin
      errors++; $display("FAIL reset_status: resp=%0d mism=%0d state=%0d expected 0/0/0", done_resp, done_mism_cnt, dbg_state);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write_read_basic();
    logic [DW-1:0] bv;
    run_cmd(1'b1, 33'h0_0000_1000, 8'd3, 8'h11, 32'h1234_0000);
    checks++;
    if (res_first !== 1) begin errors++; $display("FAIL basic_aw_latency: awvalid at %0d expected 1", res_first); end
    checks++;
    if ({res_resp, res_ill} !== 3'b000) begin errors++; $display("FAIL basic_wr_status: resp=%0d ill=%b expected 0/0", res_resp, res_ill); end
    checks++;
    if (res_again !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: second cycle done=%b expected 0", res_again); end
    bv = mem.exists(129) ? mem[129] : '0;
    checks++;
    if (bv[31:0] !== 32'h1234_0008) begin errors++; $display("FAIL basic_beat1_word0: got %h expected 12340008", bv[31:0]); end
    bv = mem.exists(131) ? mem[131] : '0;
    checks++;
    if (bv[255:224] !== 32'h1234_001F) begin errors++; $display("FAIL basic_beat3_word7: got %h expected 1234001f", bv[255:224]); end
    checks++;
    if (last_awaddr !== 33'h0_0000_1000 || last_awconst !== {3'd5, 2'b01, 4'b0011, 1'b0, 3'b000}) begin
      errors++; $display("FAIL basic_aw_fields: addr=%h const=%b", last_awaddr, last_awconst);
    end
    run_cmd(1'b0, 33'h0_0000_1000, 8'd3, 8'h11, 32'h1234_0000);
    checks++;
    if ({res_resp, res_mism, proto_err} !== 19'd0) begin
      errors++; $display("FAIL basic_rd_status: resp=%0d mism=%0d proto=%b expected 0/0/0", res_resp, res_mism, proto_err);
    end
  endtask

  task automatic test_mismatch();
    run_cmd(1'b1, 33'h2000, 8'd7, 8'h02, 32'hA5A5_0001);
    run_cmd(1'b0, 33'h2000, 8'd7, 8'h02, 32'hA5A5_0000);
    checks++;
    if (res_mism !== 16'd8) begin errors++; $display("FAIL mism_count: got %0d expected 8", res_mism); end
    checks++;
    if (res_resp !== 2'd0) begin errors++; $display("FAIL mism_resp: got %0d expected 0", res_resp); end
  endtask

  task automatic test_illegal();
    awvalid_seen = 0; arvalid_seen = 0;
    run_cmd(1'b1, 33'hFE0, 8'd1, 8'h04, 32'h0);
    checks++;
    if (res_ill !== 1'b1 || res_cyc !== 1) begin
      errors++; $display("FAIL illegal_wr: ill=%b done_at=%0d expected 1/1", res_ill, res_cyc);
    end
    run_cmd(1'b0, 33'hFE0, 8'd1, 8'h04, 32'h0);
    checks++;
    if (res_ill !== 1'b1 || res_again !== 1'b0) begin
      errors++; $display("FAIL illegal_rd: ill=%b again=%b expected 1/0", res_ill, res_again);
    end
    checks++;
    if (awvalid_seen !== 0 || arvalid_seen !== 0) begin
      errors++; $display("FAIL illegal_no_traffic: aw=%0d ar=%0d expected 0/0", awvalid_seen, arvalid_seen);
    end
    run_cmd(1'b1, 33'hFC0, 8'd1, 8'h04, 32'h7777_0000);
    checks++;
    if (res_ill !== 1'b0 || res_resp !== 2'd0) begin
      errors++; $display("FAIL edge_4k_legal: ill=%b resp=%0d expected 0/0", res_ill, res_resp);
    end
  endtask

  task automatic test_stall();
    awvalid_seen = 0; w_hs_count = 0; w_unstable = 0; wlast_err = 0; wstrb_bad = 0;
    aw_stall_left = 5; w_stall_left = 5; w_gaps = 1;
    run_cmd(1'b1, 33'h5013, 8'd5, 8'h09, 32'h0F0F_0000);
    w_gaps = 0;
    checks++;
    if (awvalid_seen !== 6) begin errors++; $display("FAIL stall_aw_hold: awvalid cycles %0d expected 6", awvalid_seen); end
    checks++;
    if (w_hs_count !== 6) begin errors++; $display("FAIL stall_w_count: got %0d expected 6", w_hs_count); end
    checks++;
    if (w_unstable !== 0 || wlast_err !== 0 || wstrb_bad !== 0) begin
      errors++; $display("FAIL stall_w_stable: unstable=%0d wlast_err=%0d strb=%0d expected 0", w_unstable, wlast_err, wstrb_bad);
    end
    checks++;
    if (last_awaddr !== 33'h5000) begin errors++; $display("FAIL stall_align: awaddr %h expected 5000", last_awaddr); end
    rresp_err_beat = 3;
    run_cmd(1'b0, 33'h5000, 8'd5, 8'h09, 32'h0F0F_0000);
    rresp_err_beat = -1;
    checks++;
    if (res_resp !== RESP_SLVERR || res_mism !== 16'd0) begin
      errors++; $display("FAIL stall_readback: resp=%0d mism=%0d expected 2/0", res_resp, res_mism);
    end
  endtask

  task automatic test_proto_rlast();
    run_cmd(1'b1, 33'h4000, 8'd3, 8'h01, 32'h0BAD_0000);
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clean: got %b expected 0", proto_err); end
    rlast_early_beat = 2;
    run_cmd(1'b0, 33'h4000, 8'd3, 8'h01, 32'h0BAD_0000);
    rlast_early_beat = -1;
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_rlast: got %b expected 1", proto_err); end
    checks++;
    if (res_again !== 1'b0 || res_mism !== 16'd0) begin
      errors++; $display("FAIL proto_rlast_done: again=%b mism=%0d expected 0/0", res_again, res_mism);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    send_cmd(1'b1, 33'h6000, 8'd7, 8'h22, 32'hC0DE_0000);
    n = 0;
    while (!(axi.wvalid === 1'b1 && axi.wdata[31:0] === 32'hC0DE_0010) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL rstmid_reach_beat2: wvalid=%b word0=%h expected beat 2", axi.wvalid, axi.wdata[31:0]); end
    rst = 1;
    #1;
    checks++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, done_valid, cmd_ready} !== 7'b0) begin
      errors++; $display("FAIL rstmid_drop: got %b expected 0000000",
        {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, done_valid, cmd_ready});
    end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || proto_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: ready=%b proto=%b expected 1/0", cmd_ready, proto_err);
    end
    run_cmd(1'b1, 33'h7000, 8'd2, 8'h33, 32'h5555_0000);
    run_cmd(1'b0, 33'h7000, 8'd2, 8'h33, 32'h5555_0000);
    checks++;
    if ({res_resp, res_mism, proto_err} !== 19'd0) begin
      errors++; $display("FAIL rstmid_clean_pair: resp=%0d mism=%0d proto=%b expected 0/0/0", res_resp, res_mism, proto_err);
    end
  endtask

  task automatic test_proto_rid();
    run_cmd(1'b1, 33'h8000, 8'd1, 8'h03, 32'h3333_0000);
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL rid_pre: got %b expected 0", proto_err); end
    rid_override = 5;
    run_cmd(1'b0, 33'h8000, 8'd1, 8'h03, 32'h3333_0000);
    rid_override = -1;
    checks++;
    if (proto_err !== 1'b1 || res_mism !== 16'd0) begin
      errors++; $display("FAIL rid_mismatch: proto=%b mism=%0d expected 1/0", proto_err, res_mism);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b1, 33'h9000, 8'd0, 8'h44, 32'hBEEF_0000);
    checks++;
    if (res_rdy_done !== 1'b0 || res_rdy_after !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: in_done=%b after=%b expected 0/1", res_rdy_done, res_rdy_after);
    end
    run_cmd(1'b0, 33'h9000, 8'd0, 8'h44, 32'hBEEF_0000);
    checks++;
    if (res_mism !== 16'd0 || res_resp !== 2'd0 || res_ill !== 1'b0) begin
      errors++; $display("FAIL b2b_read: mism=%0d resp=%0d ill=%b expected 0/0/0", res_mism, res_resp, res_ill);
    end
  endtask

  initial begin
    test_reset();
    test_write_read_basic();
    test_mismatch();
    test_illegal();
    test_stall();
    test_proto_rlast();
    test_reset_mid_burst();
    test_proto_rid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dv_axi_ram_initiator.md
Name: dv_axi_ram_initiator

Overview:
- DV-only AXI4 manager that drives single-burst write and read-back traffic into an AXI subordinate, typically the fake LPDDR RAM (dv_axi_ram) inside the LPDDR partition stub.
- Accepts one command at a time, generates a deterministic data pattern from a seed, and checks read data against that pattern.
- Reports response status, mismatch counts and protocol errors.
- Lets partition-level benches exercise the LPDDR AXI path without a full UVM agent.

Parameters:
ADDR_WIDTH, 33, AXI address width (matches fake LPDDR window).
DATA_WIDTH, 256, AXI data width; must be a multiple of 32.
ID_WIDTH, 8, AXI ID width.

Ports:
clk  in  1  sole clock; all AXI and command signals are synchronous to it.
rst  in  1  asynchronous reset, active-high.
cmd_valid/cmd_ready  in/out  1/1  command handshake.
cmd_write  in  1  1 = write burst, 0 = read-and-check burst.
cmd_addr  in  ADDR_WIDTH  start byte address.
cmd_len  in  8  AXI len (beats-1).
cmd_id  in  ID_WIDTH  AXI ID used for the burst.
cmd_seed  in  32  pattern seed.
done_valid  out  1  one-cycle completion pulse.
done_resp  out  2  write: BRESP; read: worst RRESP seen (numeric max).
done_illegal  out  1  command rejected, no AXI traffic issued.
done_mism_cnt  out  16  read beats with data mismatch (saturating).
proto_err  out  1  sticky: bad BID/RID, or RLAST position wrong.
m_axi_aw*  out  id/addr/len/size/burst/lock/cache/prot/valid, awready in.
m_axi_w*  out  data/strb/last/valid, wready in.
m_axi_b*  in  id/resp/valid, bready out.
m_axi_ar*  out  same set as AW, arready in.
m_axi_r*  in  id/data/resp/last/valid, rready out.

Behaviour:
- Reset values: all *valid, *ready and done_* outputs are 0; proto_err and counters are 0; FSM is IDLE.
- Constant outputs: size = log2(DATA_WIDTH/8); burst = INCR (2'b01); lock = 0; cache = 4'b0011; prot = 0; wstrb all ones.
- Address handling: low log2(DATA_WIDTH/8) bits of cmd_addr are zeroed on AW/AR.
- FSM states: IDLE, CHK, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - On handshake, latch all command fields, go to CHK.
- CHK (one cycle): if the aligned burst crosses a 4 KB boundary ((addr & 0xFFF) + (len+1)*bytes > 4096), set illegal and go to DONE. Otherwise go to AW (write) or AR (read).
  - Consequence: awvalid/arvalid rises 2 cycles after command acceptance.
- AW / AR: hold valid and all fields stable until ready, then go to W or R.
- W:
  - wvalid = 1; beat counter b starts at 0.
  - 32-bit word k of beat b = seed + b*(DATA_WIDTH/32) + k (mod 2^32).
  - wlast = (b == len).
  - Beat advances only on wvalid & wready. The handshake with wlast goes to B.
- B: bready = 1. On bvalid, capture bresp; if bid != id, set proto_err. Go to DONE.
- R:
  - rready = 1 continuously.
  - Each rvalid beat is compared to the pattern for beat b. Any mismatch increments mism_cnt, saturating at 0xFFFF.
  - resp_max = max(resp_max, rresp).
  - If rid != id, set proto_err.
  - If rlast != (b == len), set proto_err.
  - Leave R on rlast, or on the beat where b == len if rlast is missing.
- DONE: done_valid = 1 for exactly one cycle with done_resp, done_illegal and done_mism_cnt valid. Next state is IDLE.
- Counter and status lifetime:
  - mism_cnt, resp_max and illegal clear on command acceptance.
  - proto_err clears only on rst.
- Write data never depends on ready: pattern and wlast are functions of b only.
- Reset mid-burst: outputs drop immediately (asynchronous). The in-flight burst is abandoned; the bench must reset the subordinate too.
- Back-to-back: a new command is accepted no earlier than the cycle after done_valid.
- Write/read latency is unbounded; the block has no timeouts.

Decomposition:
- Shared package dv_axi_init_pkg holds:
  - state enum;
  - AXI constants (BURST_INCR, RESP_OKAY..DECERR, CACHE_DEFAULT);
  - function pattern_beat(seed, beat) returning DATA_WIDTH bits, used by both the write path and the read check;
  - function crosses_4k(addr, len, size).
- No sub-module: a single FSM with a beat counter is the natural structure.

Test Plan:
- Write seed 0x1234_0000, addr 0x0_0000_1000, len 3, then read same -> done_resp 0, done_mism_cnt 0, proto_err 0. Word 0 of beat 1 written as 0x1234_0008.
- Read addr 0x2000 len 7 seed 0xA5A5_0000 after writing seed 0xA5A5_0001 -> done_mism_cnt 8.
- Command addr 0xFE0 len 1 (two 32-byte beats end at 0x1020) -> done_illegal 1, no awvalid/arvalid ever asserted, done_valid 2 cycles after accept.
- Subordinate holds awready/wready low 5 cycles with random wready gaps -> wdata/wlast stable while stalled, exactly len+1 W handshakes.
- Responder returns rlast on beat 2 of len 3 (or rid 0x5 for cmd_id 0x3) -> proto_err 1, done_valid still pulses once.
- Assert rst during W beat 2 -> all valids 0 in same cycle, cmd_ready 1 after release; a subsequent write/read pair passes clean.
